// File: rtl/scan_mem_reg_mux.sv
// scan_mem_reg_mux: downstream target of the scan read/write controller.
// Takes one scan request at a time, routes it to on-chip memory, the
// register-bank req/ack interface or unmapped space, then returns a single
// scan_ready pulse with the response data. The register path has a timeout
// so a missing acknowledge can never stall the scan side.
module scan_mem_reg_mux #(
  parameter int unsigned MEM_RD_LAT  = 2,             // 1..7
  parameter int unsigned REG_TIMEOUT = 255,           // 1..255
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // scan side
  input  logic        scan_wen_i,
  input  logic        scan_ren_i,
  input  logic [15:0] scan_addr_i,
  input  logic [31:0] scan_wdata_i,
  output logic [31:0] scan_rdata_o,
  output logic        scan_ready_o,
  output logic        scan_err_o,
  output logic        busy_o,
  // memory port
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  // register bank
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [7:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ack_i
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_ACC  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_REG_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_REG  = 2'd1,
    TGT_NONE = 2'd2
  } target_e;

  localparam logic [2:0] MEM_LAT_C = 3'(MEM_RD_LAT);
  localparam logic [8:0] REG_TMO_C = 9'(REG_TIMEOUT);

  // Address map decode on the two top address bits.
  function automatic target_e decode_target(input logic [15:0] addr);
    target_e tgt;
    case (addr[15:14])
      2'b00:   tgt = TGT_MEM;
      2'b01:   tgt = TGT_REG;
      default: tgt = TGT_NONE;
    endcase
    return tgt;
  endfunction

  state_e      state_q,      state_d;
  logic        op_we_q,      op_we_d;
  logic [2:0]  mem_cnt_q,    mem_cnt_d;
  logic [7:0]  tmo_cnt_q,    tmo_cnt_d;
  logic        busy_q,       busy_d;
  logic        scan_ready_q, scan_ready_d;
  logic        scan_err_q,   scan_err_d;
  logic [31:0] scan_rdata_q, scan_rdata_d;
  logic        mem_cs_q,     mem_cs_d;
  logic        mem_we_q,     mem_we_d;
  logic [13:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic        reg_req_q,    reg_req_d;
  logic        reg_we_q,     reg_we_d;
  logic [7:0]  reg_addr_q,   reg_addr_d;
  logic [31:0] reg_wdata_q,  reg_wdata_d;

  logic        accept_s;
  logic        req_s;
  logic [8:0]  tmo_next_s;
  target_e     tgt_s;

  assign req_s      = scan_wen_i | scan_ren_i;
  // A new request is taken in IDLE or on the edge that closes RESP.
  assign accept_s   = req_s & ((state_q == ST_IDLE) | (state_q == ST_RESP));
  assign tgt_s      = decode_target(scan_addr_i);
  assign tmo_next_s = {1'b0, tmo_cnt_q} + 9'd1;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d      = state_q;
    op_we_d      = op_we_q;
    mem_cnt_d    = mem_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    busy_d       = busy_q;
    scan_ready_d = 1'b0;
    scan_err_d   = 1'b0;
    scan_rdata_d = scan_rdata_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    reg_req_d    = reg_req_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          // Write wins when both request strobes are set.
          op_we_d     = scan_wen_i;
          mem_addr_d  = scan_addr_i[13:0];
          mem_wdata_d = scan_wdata_i;
          reg_addr_d  = scan_addr_i[7:0];
          reg_wdata_d = scan_wdata_i;
          busy_d      = 1'b1;
          tmo_cnt_d   = 8'd0;
          mem_cnt_d   = 3'd0;
          case (tgt_s)
            TGT_MEM: begin
              state_d  = ST_MEM_ACC;
              mem_cs_d = 1'b1;
              mem_we_d = scan_wen_i;
            end
            TGT_REG: begin
              state_d   = ST_REG_WAIT;
              reg_req_d = 1'b1;
              reg_we_d  = scan_wen_i;
            end
            TGT_NONE: begin
              // Unmapped: answer immediately with the error pattern.
              state_d      = ST_RESP;
              scan_ready_d = 1'b1;
              scan_err_d   = 1'b1;
              scan_rdata_d = ERR_DATA;
            end
            default: begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_MEM_ACC: begin
        if (op_we_q) begin
          // Writes complete as soon as the select cycle is issued.
          state_d      = ST_RESP;
          scan_ready_d = 1'b1;
          scan_rdata_d = 32'h0000_0000;
        end else begin
          state_d   = ST_MEM_WAIT;
          mem_cnt_d = MEM_LAT_C;
        end
      end

      ST_MEM_WAIT: begin
        // The last wait cycle is the one in which mem_rdata is valid.
        if (mem_cnt_q <= 3'd1) begin
          state_d      = ST_RESP;
          scan_ready_d = 1'b1;
          scan_rdata_d = mem_rdata_i;
          mem_cnt_d    = 3'd0;
        end else begin
          mem_cnt_d = mem_cnt_q - 3'd1;
        end
      end

      ST_REG_WAIT: begin
        if (reg_ack_i) begin
          // Ack takes priority over a timeout in the same cycle.
          state_d      = ST_RESP;
          scan_ready_d = 1'b1;
          scan_rdata_d = op_we_q ? 32'h0000_0000 : reg_rdata_i;
          reg_req_d    = 1'b0;
          reg_we_d     = 1'b0;
        end else if (tmo_next_s >= REG_TMO_C) begin
          state_d      = ST_RESP;
          scan_ready_d = 1'b1;
          scan_err_d   = 1'b1;
          scan_rdata_d = ERR_DATA;
          reg_req_d    = 1'b0;
          reg_we_d     = 1'b0;
          tmo_cnt_d    = tmo_next_s[7:0];
        end else begin
          tmo_cnt_d = tmo_next_s[7:0];
        end
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        reg_req_d = 1'b0;
        reg_we_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all registered outputs; async reset clears everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      op_we_q      <= 1'b0;
      mem_cnt_q    <= 3'd0;
      tmo_cnt_q    <= 8'd0;
      busy_q       <= 1'b0;
      scan_ready_q <= 1'b0;
      scan_err_q   <= 1'b0;
      scan_rdata_q <= 32'h0000_0000;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 14'h0000;
      mem_wdata_q  <= 32'h0000_0000;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 8'h00;
      reg_wdata_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      op_we_q      <= op_we_d;
      mem_cnt_q    <= mem_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      busy_q       <= busy_d;
      scan_ready_q <= scan_ready_d;
      scan_err_q   <= scan_err_d;
      scan_rdata_q <= scan_rdata_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      reg_req_q    <= reg_req_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign scan_rdata_o = scan_rdata_q;
  assign scan_ready_o = scan_ready_q;
  assign scan_err_o   = scan_err_q;
  assign busy_o       = busy_q;
  assign mem_cs_o     = mem_cs_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign reg_req_o    = reg_req_q;
  assign reg_we_o     = reg_we_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;

endmodule
